// File: rtl/bypass_ctrl_pkg.sv
// Shared types for the ID-stage bypass controller: result kinds and the
// per-port one-hot select bundle.
package bypass_ctrl_pkg;

    localparam int KIND_W = 2;

    typedef enum logic [KIND_W-1:0] {
        KIND_ALU  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_EXT  = 2'd2,
        KIND_POP  = 2'd3
    } kind_e;

    typedef struct packed {
        logic ex;
        logic ext_ex;
        logic stack_pop;
        logic dm;
    } byp_sel_t;

    // Select for a hit on the ID_EX producer. A load has no EX-stage result,
    // so it yields no select; the load-use stall covers that case instead.
    function automatic byp_sel_t sel_from_kind(kind_e k);
        byp_sel_t s;
        s = '0;
        case (k)
            KIND_ALU: s.ex        = 1'b1;
            KIND_EXT: s.ext_ex    = 1'b1;
            KIND_POP: s.stack_pop = 1'b1;
            default:  s           = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bypass_ctrl_if.sv
// ID-stage request fields, pipeline controls and the registered bypass
// selects exchanged between the decode stage and the bypass controller.
interface bypass_ctrl_if #(parameter int ADDR_W = 5);
    import bypass_ctrl_pkg::*;

    logic              stall_ID_EX;
    logic              stall_EX_DM;
    logic              flush;
    logic              re0_ID;
    logic              re1_ID;
    logic [ADDR_W-1:0] src0_addr_ID;
    logic [ADDR_W-1:0] src1_addr_ID;
    logic              we_ID;
    logic [ADDR_W-1:0] dst_addr_ID;
    logic [KIND_W-1:0] kind_ID;

    logic byp0_EX, byp0_ext_EX, byp0_stack_pop, byp0_DM;
    logic byp1_EX, byp1_ext_EX, byp1_stack_pop, byp1_DM;
    logic load_use_stall;

    modport master (
        output stall_ID_EX, stall_EX_DM, flush,
        output re0_ID, re1_ID, src0_addr_ID, src1_addr_ID,
        output we_ID, dst_addr_ID, kind_ID,
        input  byp0_EX, byp0_ext_EX, byp0_stack_pop, byp0_DM,
        input  byp1_EX, byp1_ext_EX, byp1_stack_pop, byp1_DM,
        input  load_use_stall
    );

    modport slave (
        input  stall_ID_EX, stall_EX_DM, flush,
        input  re0_ID, re1_ID, src0_addr_ID, src1_addr_ID,
        input  we_ID, dst_addr_ID, kind_ID,
        output byp0_EX, byp0_ext_EX, byp0_stack_pop, byp0_DM,
        output byp1_EX, byp1_ext_EX, byp1_stack_pop, byp1_DM,
        output load_use_stall
    );

endinterface

// File: rtl/bypass_ctrl_byp_match.sv
// Per-source-port comparator: matches one ID source against the ID_EX and
// EX_DM producers and forms that port's next one-hot select.
module byp_match
    import bypass_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              re,
    input  logic [ADDR_W-1:0] src,
    input  logic              we1,
    input  logic [ADDR_W-1:0] dst1,
    input  kind_e             kind1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] dst2,
    output logic              m1,
    output byp_sel_t          sel_nxt
);

    logic src_live;
    logic m2;

    // Younger producer wins; r0 is never forwarded.
    always_comb begin
        src_live = re & (src != '0);
        m1       = src_live & we1 & (dst1 == src);
        m2       = src_live & we2 & (dst2 == src);
        sel_nxt  = '0;
        if (m1) begin
            sel_nxt = sel_from_kind(kind1);
        end else if (m2) begin
            sel_nxt.dm = 1'b1;
        end
    end

endmodule

// File: rtl/bypass_ctrl.sv
// ID-stage hazard/forwarding controller. Tracks the ID_EX and EX_DM
// producers, registers per-port bypass selects for EX, and raises a
// one-cycle load-use stall.
// Optional statistics counters are built when BYP_STATS_EN is defined.
module bypass_ctrl
    import bypass_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5
`ifdef BYP_STATS_EN
    ,
    parameter int STAT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    bypass_ctrl_if.slave      bus
`ifdef BYP_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] byp_cnt
`endif
);

    logic              we1, we2;
    logic [ADDR_W-1:0] dst1;
    logic [ADDR_W-1:0] dst2;
    kind_e             kind1;
    byp_sel_t          sel0_q, sel1_q;
    byp_sel_t          sel0_nxt, sel1_nxt;
    logic              m01, m11;
    logic              bubble_id;

    // EX_DM selects do not depend on the producer kind, so kind2 is not kept.
    byp_match #(.ADDR_W(ADDR_W)) u_match0 (
        .re      (bus.re0_ID),
        .src     (bus.src0_addr_ID),
        .we1     (we1),
        .dst1    (dst1),
        .kind1   (kind1),
        .we2     (we2),
        .dst2    (dst2),
        .m1      (m01),
        .sel_nxt (sel0_nxt)
    );

    byp_match #(.ADDR_W(ADDR_W)) u_match1 (
        .re      (bus.re1_ID),
        .src     (bus.src1_addr_ID),
        .we1     (we1),
        .dst1    (dst1),
        .kind1   (kind1),
        .we2     (we2),
        .dst2    (dst2),
        .m1      (m11),
        .sel_nxt (sel1_nxt)
    );

    assign bus.load_use_stall = (m01 | m11) & (kind1 == KIND_LOAD) & ~bus.flush;
    assign bubble_id          = bus.load_use_stall | bus.flush;

    // ID_EX producer and registered selects: capture, bubble or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            we1    <= 1'b0;
            dst1   <= '0;
            kind1  <= KIND_ALU;
            sel0_q <= '0;
            sel1_q <= '0;
        end else if (!bus.stall_ID_EX) begin
            if (bubble_id) begin
                we1    <= 1'b0;
                dst1   <= '0;
                kind1  <= KIND_ALU;
                sel0_q <= '0;
                sel1_q <= '0;
            end else begin
                we1    <= bus.we_ID;
                dst1   <= bus.dst_addr_ID;
                kind1  <= kind_e'(bus.kind_ID);
                sel0_q <= sel0_nxt;
                sel1_q <= sel1_nxt;
            end
        end
    end

    // EX_DM producer: advance from ID_EX, or take a bubble if ID_EX is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            we2  <= 1'b0;
            dst2 <= '0;
        end else if (!bus.stall_EX_DM) begin
            we2  <= bus.stall_ID_EX ? 1'b0 : we1;
            dst2 <= dst1;
        end
    end

    assign bus.byp0_EX        = sel0_q.ex;
    assign bus.byp0_ext_EX    = sel0_q.ext_ex;
    assign bus.byp0_stack_pop = sel0_q.stack_pop;
    assign bus.byp0_DM        = sel0_q.dm;
    assign bus.byp1_EX        = sel1_q.ex;
    assign bus.byp1_ext_EX    = sel1_q.ext_ex;
    assign bus.byp1_stack_pop = sel1_q.stack_pop;
    assign bus.byp1_DM        = sel1_q.dm;

`ifdef BYP_STATS_EN
    // Saturating counts of stall cycles and of forwarded ID_EX captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            byp_cnt   <= '0;
        end else begin
            if (bus.load_use_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!bus.stall_ID_EX && !bubble_id && ((|sel0_nxt) || (|sel1_nxt))
                && (byp_cnt != '1)) begin
                byp_cnt <= byp_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bypass_ctrl.sv
// Bench for bypass_ctrl: directed hazard scenarios followed by random
// traffic, all compared against a pipeline-slot reference model.
module tb_bypass_ctrl;

    logic clk;
    logic rst;

    bypass_ctrl_if #(.ADDR_W(5)) bus ();

`ifdef BYP_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] byp_cnt;
`endif

    bypass_ctrl #(.ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BYP_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .byp_cnt   (byp_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: contents of the two older pipeline slots.
    typedef struct {
        bit we;
        int dst;
        int kind;
    } ent_t;

    ent_t     m_ex, m_dm;
    bit [3:0] m_sel0, m_sel1;   // {EX, ext_EX, stack_pop, DM}
    longint   m_stall_cnt, m_byp_cnt;
    logic     obs_stall;

    // Nearest older writer of a source decides where its value comes from.
    function automatic bit [3:0] fwd(input bit re, input int a, output bit ld_hit);
        ld_hit = 1'b0;
        if (!re || a == 0) return 4'b0000;
        if (m_ex.we && m_ex.dst == a) begin
            case (m_ex.kind)
                0: return 4'b1000;
                2: return 4'b0100;
                3: return 4'b0010;
                default: begin
                    ld_hit = 1'b1;
                    return 4'b0000;
                end
            endcase
        end
        if (m_dm.we && m_dm.dst == a) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic cyc(input bit r, input bit s1, input bit s2, input bit fl,
                       input bit re0, input int a0, input bit re1, input int a1,
                       input bit we, input int d, input int k);
        bit [3:0] n0, n1;
        bit       l0, l1, e_stall;
        ent_t     bub, n_ex, n_dm;
        @(negedge clk);
        rst                  = r;
        bus.stall_ID_EX      = s1;
        bus.stall_EX_DM      = s2;
        bus.flush            = fl;
        bus.re0_ID           = re0;
        bus.src0_addr_ID     = 5'(a0);
        bus.re1_ID           = re1;
        bus.src1_addr_ID     = 5'(a1);
        bus.we_ID            = we;
        bus.dst_addr_ID      = 5'(d);
        bus.kind_ID          = 2'(k);
        #1;
        n0      = fwd(re0, a0, l0);
        n1      = fwd(re1, a1, l1);
        e_stall = (l0 | l1) & !fl;
        obs_stall = bus.load_use_stall;
        chk("load_use_stall", 32'(obs_stall), 32'(e_stall));
        bub  = '{we: 1'b0, dst: 0, kind: 0};
        n_ex = m_ex;
        n_dm = m_dm;
        if (r) begin
            n_ex = bub; n_dm = bub; m_sel0 = '0; m_sel1 = '0;
            m_stall_cnt = 0; m_byp_cnt = 0;
        end else begin
            if (!s2) n_dm = s1 ? bub : m_ex;
            if (!s1) begin
                if (e_stall || fl) begin
                    n_ex = bub; m_sel0 = '0; m_sel1 = '0;
                end else begin
                    n_ex = '{we: we, dst: d, kind: k};
                    m_sel0 = n0; m_sel1 = n1;
                    if ((n0 | n1) != 0) m_byp_cnt++;
                end
            end
            if (e_stall) m_stall_cnt++;
        end
        @(posedge clk);
        #1;
        m_ex = n_ex;
        m_dm = n_dm;
        chk("sel_port0", 32'({bus.byp0_EX, bus.byp0_ext_EX, bus.byp0_stack_pop, bus.byp0_DM}),
            32'(m_sel0));
        chk("sel_port1", 32'({bus.byp1_EX, bus.byp1_ext_EX, bus.byp1_stack_pop, bus.byp1_DM}),
            32'(m_sel1));
`ifdef BYP_STATS_EN
        chk("stall_cnt", stall_cnt, 32'(m_stall_cnt));
        chk("byp_cnt", byp_cnt, 32'(m_byp_cnt));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.stall_ID_EX = 0; bus.stall_EX_DM = 0; bus.flush = 0;
        bus.re0_ID = 0; bus.re1_ID = 0; bus.src0_addr_ID = '0; bus.src1_addr_ID = '0;
        bus.we_ID = 0; bus.dst_addr_ID = '0; bus.kind_ID = '0;
        m_ex = '{we: 1'b0, dst: 0, kind: 0};
        m_dm = m_ex;
        m_sel0 = '0; m_sel1 = '0; m_stall_cnt = 0; m_byp_cnt = 0;
        repeat (2) @(posedge clk);

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_byp0_EX", 32'(bus.byp0_EX), 32'd0);
        chk("reset_byp1_DM", 32'(bus.byp1_DM), 32'd0);
        idle(2);

        // ADD r3 ; ADD r5,r3,r4
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        cyc(0, 0, 0, 0, 1, 3, 1, 4, 1, 5, 0);
        chk("alu_fwd_stall", 32'(obs_stall), 32'd0);
        chk("alu_fwd_byp0_EX", 32'(bus.byp0_EX), 32'd1);
        chk("alu_fwd_byp1_any", 32'({bus.byp1_EX, bus.byp1_ext_EX, bus.byp1_stack_pop, bus.byp1_DM}), 32'd0);
        idle(2);

        // LW r7 ; ADD r2,r1,r7 (held one cycle)
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1);
        cyc(0, 0, 0, 0, 1, 1, 1, 7, 1, 2, 0);
        chk("load_use_first", 32'(obs_stall), 32'd1);
        chk("load_use_bubble_byp1", 32'({bus.byp1_EX, bus.byp1_ext_EX, bus.byp1_stack_pop, bus.byp1_DM}), 32'd0);
        cyc(0, 0, 0, 0, 1, 1, 1, 7, 1, 2, 0);
        chk("load_use_second", 32'(obs_stall), 32'd0);
        chk("load_use_byp1_DM", 32'(bus.byp1_DM), 32'd1);
        idle(2);

        // EXT r9 ; POP r9 ; read r9 on both ports
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 3);
        cyc(0, 0, 0, 0, 1, 9, 1, 9, 0, 0, 0);
        chk("pop_wins_p0", 32'(bus.byp0_stack_pop), 32'd1);
        chk("pop_wins_p1", 32'(bus.byp1_stack_pop), 32'd1);
        chk("pop_wins_ext0", 32'(bus.byp0_ext_EX), 32'd0);
        idle(2);

        // r0 is never forwarded
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        chk("r0_stall", 32'(obs_stall), 32'd0);
        chk("r0_sel0", 32'({bus.byp0_EX, bus.byp0_ext_EX, bus.byp0_stack_pop, bus.byp0_DM}), 32'd0);
        idle(2);

        // LW r4 ; consumer of r4 flushed in the same cycle
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1);
        cyc(0, 0, 0, 1, 1, 4, 0, 0, 1, 6, 0);
        chk("flush_stall", 32'(obs_stall), 32'd0);
        chk("flush_sel0", 32'({bus.byp0_EX, bus.byp0_ext_EX, bus.byp0_stack_pop, bus.byp0_DM}), 32'd0);
        idle(2);

        // pending byp0_EX held over three stall cycles, then reset mid-stall
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
        cyc(0, 0, 0, 0, 1, 6, 0, 0, 1, 8, 0);
        chk("hold_start", 32'(bus.byp0_EX), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 1, 8, 1, 6, 1, 2, 0);
            chk("hold_byp0_EX", 32'(bus.byp0_EX), 32'd1);
        end
        cyc(1, 1, 0, 0, 1, 8, 1, 6, 1, 2, 0);
        chk("reset_mid_stall", 32'({bus.byp0_EX, bus.byp0_ext_EX, bus.byp0_stack_pop, bus.byp0_DM,
                                   bus.byp1_EX, bus.byp1_ext_EX, bus.byp1_stack_pop, bus.byp1_DM}), 32'd0);
        idle(1);

        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 9) == 0),
                1'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
